// File: rtl/poly1305_verify.sv
// Receive-side sequencer for the Poly1305 core: packs a byte stream into padded 128-bit
// blocks, drives them through the core one at a time, then checks the tag in constant time.
module poly1305_verify #(
    parameter int unsigned BLK_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [127:0]         r_i,
    input  logic [127:0]         s_i,
    input  logic [127:0]         tag_i,
    input  logic                 msg_valid_i,
    input  logic [7:0]           msg_data_i,
    input  logic                 msg_last_i,
    output logic                 msg_ready_o,
    output logic [127:0]         core_r_o,
    output logic [127:0]         core_s_o,
    output logic [127:0]         core_m_o,
    output logic                 core_fb_o,
    output logic                 core_ld_o,
    output logic                 core_first_o,
    input  logic [127:0]         core_p_i,
    input  logic                 core_rdy_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ok_o,
    output logic [127:0]         tag_o,
    output logic [BLK_CNT_W-1:0] blocks_o
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    state_t               state_q;
    logic [127:0]         rKey_q;
    logic [127:0]         sKey_q;
    logic [127:0]         tagRef_q;
    logic [127:0]         m_q;
    logic                 fb_q;
    logic                 ld_q;
    logic                 first_q;
    logic                 firstFlag_q;
    logic [3:0]           byteCnt_q;
    logic                 lastBlk_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 ok_q;
    logic [127:0]         tag_q;
    logic [BLK_CNT_W-1:0] blocks_q;

    logic                 accept;
    logic                 closeBlk;
    logic [127:0]         mFill_d;

    // Block image after accepting the current byte; a closing short block also gets its 0x01 pad.
    always_comb begin
        accept   = msg_valid_i && ready_q;
        closeBlk = accept && (msg_last_i || (byteCnt_q == 4'd15));
        mFill_d  = m_q;
        for (int i = 0; i < 16; i++) begin
            if (i == int'(byteCnt_q)) begin
                mFill_d[8*i +: 8] = msg_data_i;
            end else if (msg_last_i && (i == int'(byteCnt_q) + 1)) begin
                mFill_d[8*i +: 8] = 8'h01;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rKey_q      <= '0;
            sKey_q      <= '0;
            tagRef_q    <= '0;
            m_q         <= '0;
            fb_q        <= 1'b0;
            ld_q        <= 1'b0;
            first_q     <= 1'b0;
            firstFlag_q <= 1'b0;
            byteCnt_q   <= '0;
            lastBlk_q   <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            tag_q       <= '0;
            blocks_q    <= '0;
        end else begin
            ld_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        rKey_q      <= r_i;
                        sKey_q      <= s_i;
                        tagRef_q    <= tag_i;
                        m_q         <= '0;
                        byteCnt_q   <= '0;
                        blocks_q    <= '0;
                        ok_q        <= 1'b0;
                        firstFlag_q <= 1'b1;
                        busy_q      <= 1'b1;
                        ready_q     <= 1'b1;
                        state_q     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        m_q       <= mFill_d;
                        byteCnt_q <= byteCnt_q + 4'd1;
                        if (closeBlk) begin
                            fb_q      <= (byteCnt_q == 4'd15);
                            lastBlk_q <= msg_last_i;
                            ld_q      <= 1'b1;
                            first_q   <= firstFlag_q;
                            ready_q   <= 1'b0;
                            if (blocks_q != '1) begin
                                blocks_q <= blocks_q + BLK_CNT_W'(1);
                            end
                            state_q   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    // core_p_i is what tag_q takes this edge, so comparing it here equals comparing tag_o.
                    if (core_rdy_i) begin
                        if (lastBlk_q) begin
                            tag_q   <= core_p_i;
                            ok_q    <= ~|(core_p_i ^ tagRef_q);
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            firstFlag_q <= 1'b0;
                            byteCnt_q   <= '0;
                            m_q         <= '0;
                            ready_q     <= 1'b1;
                            state_q     <= COLLECT;
                        end
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign msg_ready_o  = ready_q;
    assign core_r_o     = rKey_q;
    assign core_s_o     = sKey_q;
    assign core_m_o     = m_q;
    assign core_fb_o    = fb_q;
    assign core_ld_o    = ld_q;
    assign core_first_o = first_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign ok_o         = ok_q;
    assign tag_o        = tag_q;
    assign blocks_o     = blocks_q;

endmodule
